// File: rtl/prio_arbiter8.sv
// prio_arbiter8: eight-requester arbiter with registered one-hot grant.
// Policy is either rotating round-robin or fixed priority with index 7 highest.
// The grant is held until the owner releases it or the hold limit expires.
module prio_arbiter8 #(
    parameter bit RR_EN    = 1'b1,
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] grant_id,
    output logic       grant_valid
);

    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state, state_nx;
    logic [2:0]      last_id, last_id_nx, id_nx;
    logic [HW-1:0]   hold_cnt, hold_cnt_nx;
    logic [2:0]      start;
    logic [7:0]      others;
    logic [3:0]      pick_all, pick_oth;

    // Descending circular scan from index s.
    // The result is {found, index} of the first set bit.
    function automatic logic [3:0] pick(input logic [7:0] cand, input logic [2:0] s);
        logic [3:0] r;
        logic [2:0] idx;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            idx = s - 3'(k);
            if (!r[3] && cand[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    // Search start point and the two candidate winners (full, and owner masked off).
    always_comb begin
        start    = RR_EN ? (last_id - 3'd1) : 3'd7;
        others   = req & ~(8'd1 << grant_id);
        pick_all = pick(req, start);
        pick_oth = pick(others, start);
    end

    // Next-state logic: arbitration, release handoff and hold-limit rotation.
    always_comb begin
        state_nx    = state;
        id_nx       = grant_id;
        last_id_nx  = last_id;
        hold_cnt_nx = hold_cnt;
        case (state)
            IDLE: begin
                id_nx = 3'd0;
                if (en && pick_all[3]) begin
                    state_nx    = GRANT;
                    id_nx       = pick_all[2:0];
                    last_id_nx  = pick_all[2:0];
                    hold_cnt_nx = '0;
                end
            end
            GRANT: begin
                if (!en) begin
                    state_nx    = IDLE;
                    id_nx       = 3'd0;
                    hold_cnt_nx = '0;
                end else if (!req[grant_id]) begin
                    // The owner released. Hand off with no bubble if anyone is waiting.
                    hold_cnt_nx = '0;
                    if (pick_all[3]) begin
                        id_nx      = pick_all[2:0];
                        last_id_nx = pick_all[2:0];
                    end else begin
                        state_nx = IDLE;
                        id_nx    = 3'd0;
                    end
                end else if (hold_cnt == HOLD_LAST) begin
                    // The limit is reached. Force a rotation only when another requester waits.
                    hold_cnt_nx = '0;
                    if (pick_oth[3]) begin
                        id_nx      = pick_oth[2:0];
                        last_id_nx = pick_oth[2:0];
                    end
                end else begin
                    hold_cnt_nx = hold_cnt + HW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                id_nx    = 3'd0;
            end
        endcase
    end

    // State and registered outputs.
    // The grant is derived from the next index, so it is always one-hot or zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
            last_id     <= '0;
            hold_cnt    <= '0;
        end else begin
            state       <= state_nx;
            grant_id    <= id_nx;
            grant_valid <= (state_nx == GRANT);
            grant       <= (state_nx == GRANT) ? (8'd1 << id_nx) : 8'd0;
            last_id     <= last_id_nx;
            hold_cnt    <= hold_cnt_nx;
        end
    end

endmodule
